pulse_meter: RTL and testbench

//  Downstream stage of the max/pulse generator. Measures the length, in clock

---
 rtl/pulse_meter_if.sv | 15 +
 rtl/pulse_meter.sv | 66 ++++++
 tb/tb_pulse_meter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pulse_meter_if.sv
// pulse_meter_if: pulse input plus dav_/rfd result handshake; ovf exists only with PULSE_METER_OVF_EN.
interface pulse_meter_if #(parameter int W = 8);
  logic in;
  logic rfd;
  logic dav_;
  logic [W-1:0] z;
`ifdef PULSE_METER_OVF_EN
  logic ovf;
  modport master (output in, rfd, input dav_, z, ovf);
  modport slave (input in, rfd, output dav_, z, ovf);
`else
  modport master (output in, rfd, input dav_, z);
  modport slave (input in, rfd, output dav_, z);
`endif
endinterface

// File: rtl/pulse_meter.sv
// pulse_meter: measures high-pulse length on in and hands it out over dav_/rfd; ovf port with PULSE_METER_OVF_EN.
module pulse_meter #(
  parameter int W = 8,
  parameter int MIN_LEN = 1
) (
  input logic clock,
  input logic reset_,
  pulse_meter_if.slave m
);
  localparam logic [2:0] S_WAITLOW = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_PUSH = 3'd3;
  localparam logic [2:0] S_ACK = 3'd4;
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] MIN = W'(MIN_LEN);
  logic [2:0] state;
  logic [W-1:0] count, z;
  logic dav_;
  assign m.dav_ = dav_;
  assign m.z = z;
`ifdef PULSE_METER_OVF_EN
  // sat remembers a count attempt past MAX; ovf latches it alongside z
  logic sat, ovf;
  assign m.ovf = ovf;
  always_ff @(posedge clock or posedge reset_)
    if (reset_) begin
      sat <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (state == S_IDLE) sat <= 1'b0;
      if (state == S_COUNT && m.in && count == MAX) sat <= 1'b1;
      if (state == S_COUNT && !m.in && count >= MIN) ovf <= sat;
    end
`endif
  always_ff @(posedge clock or posedge reset_)
    if (reset_) begin
      state <= S_WAITLOW;
      count <= '0;
      z <= '0;
      dav_ <= 1'b1;
    end else
      case (state)
        S_WAITLOW: if (!m.in) state <= S_IDLE;
        S_IDLE:
          if (m.in) begin
            count <= W'(1);
            state <= S_COUNT;
          end
        S_COUNT:
          if (m.in) count <= (count == MAX) ? count : count + W'(1);
          else if (count < MIN) state <= S_IDLE;
          else begin
            z <= count;
            dav_ <= 1'b0;
            state <= S_PUSH;
          end
        S_PUSH:
          if (!m.rfd) begin
            dav_ <= 1'b1;
            state <= S_ACK;
          end
        S_ACK: if (m.rfd) state <= S_WAITLOW;
        default: state <= S_WAITLOW;
      endcase
endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: directed checks of pulse_meter (MIN_LEN=1 and MIN_LEN=3 instances).
module tb_pulse_meter;
  logic clock = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  always #5 clock = ~clock;
  pulse_meter_if #(.W(8)) a ();
  pulse_meter_if #(.W(8)) b ();
  pulse_meter #(.W(8), .MIN_LEN(1)) dut_a (.clock(clock), .reset_(rst), .m(a.slave));
  pulse_meter #(.W(8), .MIN_LEN(3)) dut_b (.clock(clock), .reset_(rst), .m(b.slave));
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic pulse_a(input int n);
    a.in = 1'b1;
    tick(n);
    a.in = 1'b0;
    tick(1);
  endtask
  task automatic pulse_b(input int n);
    b.in = 1'b1;
    tick(n);
    b.in = 1'b0;
    tick(1);
  endtask
  task automatic ack_a(input string tag);
    a.rfd = 1'b0;
    tick(1);
    chk(tag, a.dav_, 1);
    a.rfd = 1'b1;
    tick(2);
  endtask
  initial begin
    rst = 1'b1;
    a.in = 1'b0;
    a.rfd = 1'b1;
    b.in = 1'b0;
    b.rfd = 1'b1;
    tick(2);
    chk("rst_dav", a.dav_, 1);
    chk("rst_z", a.z, 0);
`ifdef PULSE_METER_OVF_EN
    chk("rst_ovf", a.ovf, 0);
`endif
    rst = 1'b0;
    tick(3);
    pulse_a(5);
    chk("t1_dav", a.dav_, 0);
    chk("t1_z", a.z, 5);
    ack_a("t1_ack");
    pulse_a(200);
    for (int i = 0; i < 10; i++) begin
      chk("t2_dav_hold", a.dav_, 0);
      chk("t2_z_hold", a.z, 200);
      tick(1);
    end
    ack_a("t2_ack");
    pulse_a(300);
    chk("t3_sat_z", a.z, 255);
`ifdef PULSE_METER_OVF_EN
    chk("t3_ovf_set", a.ovf, 1);
`endif
    ack_a("t3_ack1");
    pulse_a(255);
    chk("t3_max_z", a.z, 255);
`ifdef PULSE_METER_OVF_EN
    chk("t3_ovf_clr", a.ovf, 0);
`endif
    ack_a("t3_ack2");
    pulse_a(6);
    chk("t4_z6", a.z, 6);
    pulse_a(4);
    tick(1);
    chk("t4_lost_dav", a.dav_, 0);
    chk("t4_lost_z", a.z, 6);
    ack_a("t4_ack1");
    chk("t4_no_second", a.dav_, 1);
    pulse_a(7);
    chk("t4_dav7", a.dav_, 0);
    chk("t4_z7", a.z, 7);
    ack_a("t4_ack2");
    a.rfd = 1'b0;
    pulse_a(3);
    chk("push_rfd0_dav", a.dav_, 0);
    chk("push_rfd0_z", a.z, 3);
    tick(1);
    chk("push_rfd0_rise", a.dav_, 1);
    a.rfd = 1'b1;
    tick(2);
    a.in = 1'b1;
    tick(20);
    rst = 1'b1;
    #2;
    chk("t5_async_z", a.z, 0);
    chk("t5_async_dav", a.dav_, 1);
    rst = 1'b0;
    tick(30);
    a.in = 1'b0;
    tick(3);
    chk("t5_tail_ignored", a.dav_, 1);
    pulse_a(9);
    chk("t5_z9", a.z, 9);
    ack_a("t5_ack");
    pulse_b(2);
    tick(2);
    chk("t6_short_drop", b.dav_, 1);
    pulse_b(3);
    chk("t6_min_dav", b.dav_, 0);
    chk("t6_min_z", b.z, 3);
    b.rfd = 1'b0;
    tick(1);
    chk("t6_ack", b.dav_, 1);
    b.rfd = 1'b1;
    tick(2);
    pulse_a(17);
    chk("e2e_max17", a.z, 17);
    ack_a("e2e_ack");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
